// File: rtl/bcd_key_entry.sv
// Keypad digit-entry buffer: assembles up to four BCD digits and
// hands the committed value downstream over a valid/ack pair.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   key_code         0-9 digit, CODE_CLR, CODE_BSP or CODE_ENT
//   key_valid        key_code offered this cycle
//   key_ready        key accepted when key_valid && key_ready
//   live             edit buffer {th, hu, te, un}, BCD
//   count            digits currently entered, 0..4
//   N1..N4           committed digits, thousands..units
//   out_valid        N1..N4 hold a committed value
//   out_ack          consumer has taken N1..N4
//   err              one-cycle pulse on a rejected key
module bcd_key_entry #(
  parameter logic [3:0] CODE_CLR = 4'hA,
  parameter logic [3:0] CODE_BSP = 4'hB,
  parameter logic [3:0] CODE_ENT = 4'hC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [15:0] live,
  output logic [2:0]  count,
  output logic [3:0]  N1,
  output logic [3:0]  N2,
  output logic [3:0]  N3,
  output logic [3:0]  N4,
  output logic        out_valid,
  input  logic        out_ack,
  output logic        err
);

  typedef enum logic {
    EDIT = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [15:0] live_q, live_nx;
  logic [2:0]  cnt_q, cnt_nx;
  logic [15:0] n_q, n_nx;
  logic        err_q, err_nx;

  logic take;
  logic is_dig;
  logic is_clr;
  logic is_bsp;
  logic is_ent;
  logic full;
  logic empty;

  assign take   = key_valid && (state == EDIT);
  assign is_dig = key_code < 4'd10;
  assign is_clr = key_code == CODE_CLR;
  assign is_bsp = key_code == CODE_BSP;
  assign is_ent = key_code == CODE_ENT;
  assign full   = cnt_q == 3'd4;
  assign empty  = cnt_q == 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EDIT;
      live_q <= '0;
      cnt_q  <= '0;
      n_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      live_q <= live_nx;
      cnt_q  <= cnt_nx;
      n_q    <= n_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    live_nx  = live_q;
    cnt_nx   = cnt_q;
    n_nx     = n_q;
    err_nx   = 1'b0;
    unique case (state)
      EDIT: begin
        if (take) begin
          unique case (1'b1)
            is_dig: begin
              if (full) begin
                err_nx = 1'b1;
              end else begin
                live_nx = {live_q[11:0], key_code};
                cnt_nx  = cnt_q + 3'd1;
              end
            end
            is_bsp: begin
              if (!empty) begin
                live_nx = {4'h0, live_q[15:4]};
                cnt_nx  = cnt_q - 3'd1;
              end
            end
            is_clr: begin
              live_nx = '0;
              cnt_nx  = '0;
            end
            is_ent: begin
              if (empty) begin
                err_nx = 1'b1;
              end else begin
                // live stays so the display keeps the value
                n_nx     = live_q;
                state_nx = HOLD;
              end
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        // a key offered alongside ack waits for EDIT
        if (out_ack) begin
          live_nx  = '0;
          cnt_nx   = '0;
          state_nx = EDIT;
        end
      end
      default: state_nx = EDIT;
    endcase
  end

  always_comb begin
    // no key is taken while reset is held
    key_ready = (state == EDIT) && !rst;
    out_valid = state == HOLD;
    live      = live_q;
    count     = cnt_q;
    N1        = n_q[15:12];
    N2        = n_q[11:8];
    N3        = n_q[7:4];
    N4        = n_q[3:0];
    err       = err_q;
  end

endmodule
